branch_merger: RTL and testbench
================================

# branch_merger

Return-path counterpart of the branch router: collects completed results from the `N_INSTR_BRANCHES` execution branches and merges them into one registered stream toward the commit/writeback stage. Uses round-robin arbitration across branches with a valid/ready handshake on every input and on the output. Output is a single register stage, so sustained throughput is one result per cycle.

## Interface
- `data_width`, 16, width of the result value
- `n_blocks`, 256, number of blocks; sets the block-index width `$clog2(n_blocks)`
- `full_width`, `2*data_width+8`, accumulator width
- `n_branches`, `` `N_INSTR_BRANCHES ``, number of merged branches; a fixed parameter, derived from the shared header
- `clk`  in  1  single clock; all state is rising-edge
- `reset`  in  1  asynchronous, active-low (0 = reset)
- `enable`  in  1  global advance; when low, all state is frozen
- `in_valid`  in  n_branches  per-branch result valid
- `in_ready`  out  n_branches  per-branch accept; one-hot or zero
- `block_in`  in  n_branches*$clog2(n_blocks)  packed per branch; branch i at slice i
- `dest_in`  in  n_branches*4  destination register, packed
- `result_in`  in  n_branches*data_width  result value, signed, packed
- `accumulator_in`  in  n_branches*full_width  accumulator value, packed
- `accumulator_valid_in`  in  n_branches  accumulator field is meaningful
- `writes_external_in`  in  n_branches  result targets external memory
- `res_addr_in`  in  n_branches*8  external resource address, packed
- `commit_id_in`  in  n_branches*`COMMIT_ID_WIDTH`  commit id, packed
- `commit_flag_in`  in  n_branches  commit flag, packed
- `out_valid`  out  1  merged result valid
- `out_ready`  in  1  downstream accept
- `branch_out`  out  $clog2(n_branches) (min 1)  index of the source branch
- `block_out`, `dest_out`, `result_out`, `accumulator_out`, `accumulator_valid_out`, `writes_external_out`, `res_addr_out`, `commit_id_out`, `commit_flag_out`  out  single-branch width  registered copy of the granted branch's fields

## Operation
- Round-robin pointer `rr_ptr` (0..n_branches-1):
  - Grant goes to the first asserted `in_valid[j]`, scanning j = rr_ptr, rr_ptr+1, ..., with wrap-around modulo n_branches.
- `slot_free = ~out_valid | out_ready`.
- `in_ready = enable & slot_free ? onehot(grant) : 0`.
  - `in_ready` is zero when no input is valid.
  - The grant is combinational from the current `in_valid` and `rr_ptr`.
- `take_in = |(in_valid & in_ready)`.
- `take_out = out_valid & out_ready`.
- Registered updates, only while `enable` = 1:
  - On `take_in`: all output fields load from the granted slice; `branch_out` loads the grant index; `out_valid` goes to 1; `rr_ptr` goes to (grant+1) mod n_branches.
  - On `take_out` without `take_in`: `out_valid` goes to 0; data registers hold.
  - On simultaneous `take_out` and `take_in`: the output reloads with no bubble.
  - Otherwise: everything holds.
- `enable` = 0:
  - `in_ready` = 0 and no state changes.
  - `out_valid` keeps its value and the output data stays stable.
  - A downstream `out_ready` seen while `enable` = 0 is ignored, so the result is not consumed.
- Upstream must hold a branch's fields stable while its `in_valid` is high and not yet accepted; the merger does not latch unaccepted inputs.
- Pure transport: no arithmetic and no width changes. `result` and `accumulator` are passed through bit-exact, including sign.

## Timing
- Reset (`reset` low, asynchronous): `out_valid`=0, `rr_ptr`=0, and every data output = 0, including `branch_out`.
  - Reset asserted mid-transfer drops the held result with no handshake.
  - First acceptance is possible in the first clock edge after `reset` deasserts.
- Latency: 1 cycle from input acceptance to `out_valid`.
- Throughput: 1 result per cycle while `out_ready` = 1.
- Output stall (`out_ready`=0 with `out_valid`=1): `in_ready` = 0 for all branches; `rr_ptr` is frozen.
- Fairness: with all branches continuously valid, grants rotate 0,1,...,n-1,0; no branch waits more than n_branches-1 acceptances.
- n_branches = 1: pointer stays 0 and the block degenerates to a single register slice.

## Structure
- `` `N_INSTR_BRANCHES `` and `` `COMMIT_ID_WIDTH `` come from the shared headers `instr_dec.vh` and `core.vh`; no new constants are added there.
- One sub-module, `rr_arbiter`, parameterised by n_branches:
  - inputs: request vector, pointer, advance strobe;
  - outputs: one-hot grant and grant index;
  - owns `rr_ptr` with async active-low reset.
- Field unpacking and the output register live in `branch_merger`.

## Test plan
- Single branch: branch 2 presents `result_in`=0x7FFF, `commit_id`=5 with `out_ready`=1 → `in_ready`=0b0100 that cycle; next cycle `out_valid`=1, `branch_out`=2, `result_out`=0x7FFF, `commit_id_out`=5.
- Contention: all branches valid and held, `out_ready`=1 for 2n cycles → `branch_out` sequence is 0,1,...,n-1,0,...; one output per cycle with no bubbles.
- Backpressure: `out_ready`=0 for 4 cycles with output valid → `in_ready`=0 and outputs frozen; on release the held result transfers, a new grant loads the same cycle, and `out_valid` stays 1.
- `enable` low for 3 cycles while `out_valid`=1 and `out_ready`=1 → no transfer, no pointer change; the transfer completes on the first enabled cycle.
- Reset mid-stream: assert `reset` low asynchronously between edges while `out_valid`=1 → `out_valid`, `branch_out` and the data outputs read 0 immediately; after release the first grant comes from branch 0 when all branches are valid.
- Signed extremes: `result_in`=0x8000 and `accumulator_in` = most negative `full_width` value → reproduced bit-exact on the output.

Source files
------------

// File: rtl/branch_merger_pkg.sv
// rtl/branch_merger_pkg.sv - shared widths and helpers for the branch merger
// Core-header constants fall back to these defaults when the shared headers are not included.
`ifndef N_INSTR_BRANCHES
`define N_INSTR_BRANCHES 4
`endif
`ifndef COMMIT_ID_WIDTH
`define COMMIT_ID_WIDTH 4
`endif

package branch_merger_pkg;
   localparam int N_BRANCHES      = `N_INSTR_BRANCHES;
   localparam int COMMIT_ID_WIDTH = `COMMIT_ID_WIDTH;
   localparam int DEST_WIDTH      = 4;
   localparam int RES_ADDR_WIDTH  = 8;

   // Index width that stays at least one bit for single-entry vectors.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/branch_merger_rr_arbiter.sv
// rtl/branch_merger_rr_arbiter.sv - round-robin arbiter owning the rotating priority pointer
// Grant is combinational from req_i and the pointer; the pointer moves past the winner on advance_i.
module rr_arbiter
   import branch_merger_pkg::*;
#(
   parameter int N = 4,
   localparam int IW = idx_width(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req_i,
   input  logic          advance_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] grant_idx_o
);
   logic [IW-1:0] ptr_q, ptr_d;
   int            idx;

   // Scan downward so the lowest offset from the pointer is written last and wins.
   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      idx         = 0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = (int'(ptr_q) + k) % N;
         if (req_i[idx]) begin
            grant_o     = N'(1) << idx;
            grant_idx_o = IW'(idx);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance_i) begin
         if (int'(grant_idx_o) >= N - 1) ptr_d = '0;
         else                           ptr_d = grant_idx_o + IW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end
endmodule

// File: rtl/branch_merger.sv
// rtl/branch_merger.sv - merges per-branch results into one registered valid/ready stream
// Round-robin grant feeds a single output register slice; enable freezes all state.
module branch_merger
   import branch_merger_pkg::*;
#(
   parameter int data_width = 16,
   parameter int n_blocks   = 256,
   parameter int full_width = 2 * data_width + 8,
   localparam int n_branches = N_BRANCHES,
   localparam int bw = $clog2(n_blocks),
   localparam int iw = idx_width(n_branches),
   localparam int cw = COMMIT_ID_WIDTH,
   localparam int dw = DEST_WIDTH,
   localparam int aw = RES_ADDR_WIDTH
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             enable,
   input  logic [n_branches-1:0]            in_valid,
   output logic [n_branches-1:0]            in_ready,
   input  logic [n_branches*bw-1:0]         block_in,
   input  logic [n_branches*dw-1:0]         dest_in,
   input  logic [n_branches*data_width-1:0] result_in,
   input  logic [n_branches*full_width-1:0] accumulator_in,
   input  logic [n_branches-1:0]            accumulator_valid_in,
   input  logic [n_branches-1:0]            writes_external_in,
   input  logic [n_branches*aw-1:0]         res_addr_in,
   input  logic [n_branches*cw-1:0]         commit_id_in,
   input  logic [n_branches-1:0]            commit_flag_in,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [iw-1:0]                    branch_out,
   output logic [bw-1:0]                    block_out,
   output logic [dw-1:0]                    dest_out,
   output logic [data_width-1:0]            result_out,
   output logic [full_width-1:0]            accumulator_out,
   output logic                             accumulator_valid_out,
   output logic                             writes_external_out,
   output logic [aw-1:0]                    res_addr_out,
   output logic [cw-1:0]                    commit_id_out,
   output logic                             commit_flag_out
);
   logic [n_branches-1:0] grant;
   logic [iw-1:0]         grant_idx;
   logic                  slot_free, take_in, take_out;
   int                    gi;

   logic                  valid_q, valid_d;
   logic [iw-1:0]         branch_q, branch_d;
   logic [bw-1:0]         block_q, block_d;
   logic [dw-1:0]         dest_q, dest_d;
   logic [data_width-1:0] result_q, result_d;
   logic [full_width-1:0] acc_q, acc_d;
   logic                  acc_valid_q, acc_valid_d;
   logic                  wext_q, wext_d;
   logic [aw-1:0]         res_addr_q, res_addr_d;
   logic [cw-1:0]         commit_id_q, commit_id_d;
   logic                  commit_flag_q, commit_flag_d;

   rr_arbiter #(.N(n_branches)) u_arb (
      .clk        (clk),
      .rst_n      (reset),
      .req_i      (in_valid),
      .advance_i  (take_in),
      .grant_o    (grant),
      .grant_idx_o(grant_idx)
   );

   assign slot_free = ~valid_q | out_ready;
   assign in_ready  = (enable & slot_free) ? grant : '0;
   assign take_in   = |(in_valid & in_ready);
   // Downstream consumption only counts while enabled, so a frozen result is never lost.
   assign take_out  = enable & valid_q & out_ready;
   assign gi        = int'(grant_idx);

   always_comb begin
      valid_d       = valid_q;
      branch_d      = branch_q;
      block_d       = block_q;
      dest_d        = dest_q;
      result_d      = result_q;
      acc_d         = acc_q;
      acc_valid_d   = acc_valid_q;
      wext_d        = wext_q;
      res_addr_d    = res_addr_q;
      commit_id_d   = commit_id_q;
      commit_flag_d = commit_flag_q;
      if (take_in) begin
         valid_d       = 1'b1;
         branch_d      = grant_idx;
         block_d       = block_in[gi*bw +: bw];
         dest_d        = dest_in[gi*dw +: dw];
         result_d      = result_in[gi*data_width +: data_width];
         acc_d         = accumulator_in[gi*full_width +: full_width];
         acc_valid_d   = accumulator_valid_in[gi];
         wext_d        = writes_external_in[gi];
         res_addr_d    = res_addr_in[gi*aw +: aw];
         commit_id_d   = commit_id_in[gi*cw +: cw];
         commit_flag_d = commit_flag_in[gi];
      end else if (take_out) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q       <= 1'b0;
         branch_q      <= '0;
         block_q       <= '0;
         dest_q        <= '0;
         result_q      <= '0;
         acc_q         <= '0;
         acc_valid_q   <= 1'b0;
         wext_q        <= 1'b0;
         res_addr_q    <= '0;
         commit_id_q   <= '0;
         commit_flag_q <= 1'b0;
      end else begin
         valid_q       <= valid_d;
         branch_q      <= branch_d;
         block_q       <= block_d;
         dest_q        <= dest_d;
         result_q      <= result_d;
         acc_q         <= acc_d;
         acc_valid_q   <= acc_valid_d;
         wext_q        <= wext_d;
         res_addr_q    <= res_addr_d;
         commit_id_q   <= commit_id_d;
         commit_flag_q <= commit_flag_d;
      end
   end

   assign out_valid             = valid_q;
   assign branch_out            = branch_q;
   assign block_out             = block_q;
   assign dest_out              = dest_q;
   assign result_out            = result_q;
   assign accumulator_out       = acc_q;
   assign accumulator_valid_out = acc_valid_q;
   assign writes_external_out   = wext_q;
   assign res_addr_out          = res_addr_q;
   assign commit_id_out         = commit_id_q;
   assign commit_flag_out       = commit_flag_q;
endmodule

// File: tb/tb_branch_merger.sv
// tb/tb_branch_merger.sv - table-driven and directed sequence bench for branch_merger
module tb_branch_merger;
   import branch_merger_pkg::*;
   localparam int N  = N_BRANCHES;
   localparam int DW = 16;
   localparam int BW = 8;
   localparam int FW = 40;
   localparam int CW = COMMIT_ID_WIDTH;
   localparam int IW = idx_width(N);

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic enable = 1'b0;
   logic out_ready = 1'b0;
   logic [N-1:0] in_valid = '0;
   logic [N-1:0] in_ready;

   logic [BW-1:0] blk[N];
   logic [3:0]    dst[N];
   logic [DW-1:0] res[N];
   logic [FW-1:0] acc[N];
   logic [7:0]    raddr[N];
   logic [CW-1:0] cid[N];
   logic [N-1:0]  accv, wext, cflag;

   logic [N*BW-1:0] block_in;
   logic [N*4-1:0]  dest_in;
   logic [N*DW-1:0] result_in;
   logic [N*FW-1:0] accumulator_in;
   logic [N*8-1:0]  res_addr_in;
   logic [N*CW-1:0] commit_id_in;

   logic          out_valid;
   logic [IW-1:0] branch_out;
   logic [BW-1:0] block_out;
   logic [3:0]    dest_out;
   logic [DW-1:0] result_out;
   logic [FW-1:0] accumulator_out;
   logic          accumulator_valid_out, writes_external_out, commit_flag_out;
   logic [7:0]    res_addr_out;
   logic [CW-1:0] commit_id_out;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [3:0] valid;
      logic       rdy;
      logic       en;
      logic [3:0] exp_ir;
      logic       exp_ov;
      int         exp_br;
   } vec_t;
   vec_t tv[14];

   always #5 clk = ~clk;

   always_comb begin
      block_in = '0; dest_in = '0; result_in = '0;
      accumulator_in = '0; res_addr_in = '0; commit_id_in = '0;
      for (int i = 0; i < N; i++) begin
         block_in[i*BW +: BW]       = blk[i];
         dest_in[i*4 +: 4]          = dst[i];
         result_in[i*DW +: DW]      = res[i];
         accumulator_in[i*FW +: FW] = acc[i];
         res_addr_in[i*8 +: 8]      = raddr[i];
         commit_id_in[i*CW +: CW]   = cid[i];
      end
   end

   branch_merger dut (
      .clk(clk), .reset(reset), .enable(enable),
      .in_valid(in_valid), .in_ready(in_ready),
      .block_in(block_in), .dest_in(dest_in), .result_in(result_in),
      .accumulator_in(accumulator_in), .accumulator_valid_in(accv),
      .writes_external_in(wext), .res_addr_in(res_addr_in),
      .commit_id_in(commit_id_in), .commit_flag_in(cflag),
      .out_valid(out_valid), .out_ready(out_ready), .branch_out(branch_out),
      .block_out(block_out), .dest_out(dest_out), .result_out(result_out),
      .accumulator_out(accumulator_out), .accumulator_valid_out(accumulator_valid_out),
      .writes_external_out(writes_external_out), .res_addr_out(res_addr_out),
      .commit_id_out(commit_id_out), .commit_flag_out(commit_flag_out)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_defaults();
      for (int i = 0; i < N; i++) begin
         blk[i]   = 8'(8'h10 + i);
         dst[i]   = 4'(i + 1);
         res[i]   = 16'(16'hA000 + i);
         acc[i]   = 40'(40'h55_0000_0000 + i);
         raddr[i] = 8'(8'h80 + i);
         cid[i]   = CW'(i);
         accv[i]  = (i % 2) == 1;
         wext[i]  = (i % 2) == 0;
         cflag[i] = (i / 2) == 1;
      end
   endtask

   task automatic check_fields(input string tag, input int b);
      chk({tag, " block"},     64'(block_out),             64'(blk[b]));
      chk({tag, " dest"},      64'(dest_out),              64'(dst[b]));
      chk({tag, " result"},    64'(result_out),            64'(res[b]));
      chk({tag, " acc"},       64'(accumulator_out),       64'(acc[b]));
      chk({tag, " acc_valid"}, 64'(accumulator_valid_out), 64'(accv[b]));
      chk({tag, " wext"},      64'(writes_external_out),   64'(wext[b]));
      chk({tag, " res_addr"},  64'(res_addr_out),          64'(raddr[b]));
      chk({tag, " commit_id"}, 64'(commit_id_out),         64'(cid[b]));
      chk({tag, " cflag"},     64'(commit_flag_out),       64'(cflag[b]));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tv[0]  = '{4'b0100, 1'b1, 1'b1, 4'b0100, 1'b1, 2};
      tv[1]  = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 2};
      tv[2]  = '{4'b1111, 1'b1, 1'b1, 4'b1000, 1'b1, 3};
      tv[3]  = '{4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 0};
      tv[4]  = '{4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1, 1};
      tv[5]  = '{4'b1111, 1'b0, 1'b1, 4'b0000, 1'b1, 1};
      tv[6]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 1'b1, 1};
      tv[7]  = '{4'b0011, 1'b1, 1'b1, 4'b0001, 1'b1, 0};
      tv[8]  = '{4'b0011, 1'b1, 1'b1, 4'b0010, 1'b1, 1};
      tv[9]  = '{4'b1010, 1'b0, 1'b1, 4'b0000, 1'b1, 1};
      tv[10] = '{4'b1010, 1'b1, 1'b1, 4'b1000, 1'b1, 3};
      tv[11] = '{4'b1010, 1'b1, 1'b1, 4'b0010, 1'b1, 1};
      tv[12] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 1};
      tv[13] = '{4'b0001, 1'b0, 1'b1, 4'b0001, 1'b1, 0};
      set_defaults();

      #12;
      chk("reset out_valid", 64'(out_valid), 64'd0);
      chk("reset branch_out", 64'(branch_out), 64'd0);
      chk("reset result_out", 64'(result_out), 64'd0);
      chk("reset acc_out", 64'(accumulator_out), 64'd0);
      chk("reset in_ready", 64'(in_ready), 64'd0);
      reset = 1'b1;

      for (int t = 0; t < 14; t++) begin
         in_valid = tv[t].valid; out_ready = tv[t].rdy; enable = tv[t].en;
         #2;
         chk($sformatf("vec%0d in_ready", t), 64'(in_ready), 64'(tv[t].exp_ir));
         tick();
         chk($sformatf("vec%0d out_valid", t), 64'(out_valid), 64'(tv[t].exp_ov));
         chk($sformatf("vec%0d branch_out", t), 64'(branch_out), 64'(tv[t].exp_br));
         check_fields($sformatf("vec%0d", t), tv[t].exp_br);
      end

      // single branch 2 with a max positive result
      res[2] = 16'h7FFF; cid[2] = CW'(5);
      in_valid = 4'b0100; out_ready = 1'b1; enable = 1'b1;
      #2;
      chk("single in_ready", 64'(in_ready), 64'b0100);
      tick();
      chk("single out_valid", 64'(out_valid), 64'd1);
      chk("single branch_out", 64'(branch_out), 64'd2);
      chk("single result", 64'(result_out), 64'h7FFF);
      chk("single commit_id", 64'(commit_id_out), 64'd5);

      // asynchronous reset between edges while holding a result
      reset = 1'b0;
      #1;
      chk("midreset out_valid", 64'(out_valid), 64'd0);
      chk("midreset branch_out", 64'(branch_out), 64'd0);
      chk("midreset result", 64'(result_out), 64'd0);
      chk("midreset commit_id", 64'(commit_id_out), 64'd0);
      set_defaults();
      reset = 1'b1;
      in_valid = 4'b1111; out_ready = 1'b1; enable = 1'b1;
      #1;
      chk("post-reset in_ready", 64'(in_ready), 64'b0001);

      for (int k = 0; k < 2 * N; k++) begin
         tick();
         chk($sformatf("contend%0d out_valid", k), 64'(out_valid), 64'd1);
         chk($sformatf("contend%0d branch_out", k), 64'(branch_out), 64'(k % N));
         chk($sformatf("contend%0d result", k), 64'(result_out), 64'(res[k % N]));
      end

      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("stall%0d in_ready", k), 64'(in_ready), 64'd0);
         tick();
         chk($sformatf("stall%0d out_valid", k), 64'(out_valid), 64'd1);
         chk($sformatf("stall%0d branch_out", k), 64'(branch_out), 64'd3);
         chk($sformatf("stall%0d result", k), 64'(result_out), 64'(res[3]));
      end
      out_ready = 1'b1;
      #1;
      chk("release in_ready", 64'(in_ready), 64'b0001);
      tick();
      chk("release out_valid", 64'(out_valid), 64'd1);
      chk("release branch_out", 64'(branch_out), 64'd0);

      enable = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("disabled%0d in_ready", k), 64'(in_ready), 64'd0);
         tick();
         chk($sformatf("disabled%0d out_valid", k), 64'(out_valid), 64'd1);
         chk($sformatf("disabled%0d branch_out", k), 64'(branch_out), 64'd0);
         chk($sformatf("disabled%0d result", k), 64'(result_out), 64'(res[0]));
      end
      enable = 1'b1;
      #1;
      chk("reenable in_ready", 64'(in_ready), 64'b0010);
      tick();
      chk("reenable out_valid", 64'(out_valid), 64'd1);
      chk("reenable branch_out", 64'(branch_out), 64'd1);

      res[1] = 16'h8000; acc[1] = 40'h80_0000_0000;
      in_valid = 4'b0010;
      #1;
      chk("signed in_ready", 64'(in_ready), 64'b0010);
      tick();
      chk("signed branch_out", 64'(branch_out), 64'd1);
      chk("signed result", 64'(result_out), 64'h8000);
      chk("signed acc", 64'(accumulator_out), 64'h80_0000_0000);

      in_valid = 4'b0000;
      tick();
      chk("drain out_valid", 64'(out_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
